// File: rtl/ripple_add_sequencer_pkg.sv
// Shared types and constants for the byte-serial wide adder.
// Optional signed-overflow output is enabled with ADD_SEQ_OVF_EN.
package add_seq_pkg;
   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Width of the byte index counter for a given slice count.
   function automatic int idx_w(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction
endpackage

// File: rtl/ripple_add_sequencer_if.sv
// Request/response bundle between requester, sequencer and result consumer.
// The ovf signal exists only when ADD_SEQ_OVF_EN is defined.
interface ripple_add_sequencer_if
   import add_seq_pkg::*;
#(
   parameter int WORDS = 4
);
   localparam int W = BYTE_W * WORDS;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
`ifdef ADD_SEQ_OVF_EN
   logic         ovf;

   modport master (output in_valid, a, b, cin, out_ready,
                   input  in_ready, out_valid, sum, cout, ovf);
   modport slave  (input  in_valid, a, b, cin, out_ready,
                   output in_ready, out_valid, sum, cout, ovf);
`else
   modport master (output in_valid, a, b, cin, out_ready,
                   input  in_ready, out_valid, sum, cout);
   modport slave  (input  in_valid, a, b, cin, out_ready,
                   output in_ready, out_valid, sum, cout);
`endif
endinterface

// File: rtl/ripple_add_sequencer_adder.sv
// 8-bit ripple-carry adder used as the shared byte datapath.
module ripple_ca_adder
   import add_seq_pkg::*;
(
   input  logic [BYTE_W-1:0] a_i,
   input  logic [BYTE_W-1:0] b_i,
   input  logic              c_i,
   output logic [BYTE_W-1:0] s_o,
   output logic              c_o
);
   always_comb begin
      logic c;
      c   = c_i;
      s_o = '0;
      for (int i = 0; i < BYTE_W; i++) begin
         s_o[i] = a_i[i] ^ b_i[i] ^ c;
         c      = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
      end
      c_o = c;
   end
endmodule

// File: rtl/ripple_add_sequencer.sv
// WORDS x 8-bit adder that reuses one 8-bit ripple adder, LSB byte first.
// Define ADD_SEQ_OVF_EN to add the registered signed-overflow flag.
module ripple_add_sequencer
   import add_seq_pkg::*;
#(
   parameter int WORDS = 4
)(
   input  logic                  clk,
   input  logic                  rst_n,
   ripple_add_sequencer_if.slave bus
);
   localparam int W  = BYTE_W * WORDS;
   localparam int IW = idx_w(WORDS);
   localparam logic [1:0]    ST_IDLE = IDLE;
   localparam logic [1:0]    ST_ADD  = ADD;
   localparam logic [1:0]    ST_DONE = DONE;
   localparam logic [IW-1:0] LAST    = IW'(WORDS - 1);

   logic [1:0]        state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic              carry_q, carry_d;
   logic [W-1:0]      a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic              cout_q, cout_d;
   logic              vld_q, vld_d;
   logic [BYTE_W-1:0] add_a, add_b, add_s;
   logic              add_c;
`ifdef ADD_SEQ_OVF_EN
   logic              ovf_q, ovf_d;
`endif

   assign add_a = a_q[BYTE_W*idx_q +: BYTE_W];
   assign add_b = b_q[BYTE_W*idx_q +: BYTE_W];

   ripple_ca_adder u_add (
      .a_i (add_a),
      .b_i (add_b),
      .c_i (carry_q),
      .s_o (add_s),
      .c_o (add_c)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      vld_d   = vld_q;
`ifdef ADD_SEQ_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         ST_IDLE: if (bus.in_valid) begin
            a_d     = bus.a;
            b_d     = bus.b;
            carry_d = bus.cin;
            idx_d   = '0;
            state_d = ST_ADD;
         end
         ST_ADD: begin
            sum_d[BYTE_W*idx_q +: BYTE_W] = add_s;
            carry_d = add_c;
            if (idx_q == LAST) begin
               cout_d  = add_c;
               vld_d   = 1'b1;
               state_d = ST_DONE;
`ifdef ADD_SEQ_OVF_EN
               // Top byte's sum MSB is the result sign bit.
               ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_s[BYTE_W-1] != a_q[W-1]);
`endif
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_DONE: if (bus.out_ready) begin
            vld_d   = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            vld_d   = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         vld_q   <= 1'b0;
`ifdef ADD_SEQ_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         vld_q   <= vld_d;
`ifdef ADD_SEQ_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = vld_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
`ifdef ADD_SEQ_OVF_EN
   assign bus.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_ripple_add_sequencer.sv
// Scoreboard bench for ripple_add_sequencer (WORDS=4), directed vectors.
module tb_ripple_add_sequencer;
   localparam int WORDS = 4;

   typedef struct {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_hs = -1;
   int   acc_q[$];
   exp_t expq[$];

   ripple_add_sequencer_if #(.WORDS(WORDS)) bus ();

   ripple_add_sequencer #(.WORDS(WORDS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out", name);
   endtask

   // Accept and handshake log, sampled before the DUT updates on the edge.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
      if (bus.out_valid && bus.out_ready) last_hs = cyc;
   end

   // Monitor: any presented result must match the head of the scoreboard.
   always @(negedge clk) begin
      if (bus.out_valid) begin
         if (expq.size() == 0) begin
            timeout("spurious_out_valid");
         end else begin
            chk("sum",  bus.sum,  expq[0].sum);
            chk("cout", bus.cout, expq[0].cout);
`ifdef ADD_SEQ_OVF_EN
            chk("ovf",  bus.ovf,  expq[0].ovf);
`endif
            if (bus.out_ready) void'(expq.pop_front());
         end
      end
   end

   task automatic push(input logic [31:0] s, input logic c, input logic o);
      exp_t e;
      e.sum = s; e.cout = c; e.ovf = o;
      expq.push_back(e);
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic c, input bit keep);
      int n;
      bit ok;
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.a = a; bus.b = b; bus.cin = c;
      n  = acc_q.size();
      ok = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         if (acc_q.size() > n) begin ok = 1; break; end
      end
      if (!ok) timeout("accept");
      if (!keep) bus.in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         if (bus.in_ready && expq.size() == 0) begin ok = 1; break; end
      end
      if (!ok) timeout("wait_idle");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int n0;
      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
      bus.out_ready = 1'b1;
      #2;
      chk("rst_in_ready",  bus.in_ready,  1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_sum",       bus.sum,       0);
      chk("rst_cout",      bus.cout,      0);
`ifdef ADD_SEQ_OVF_EN
      chk("rst_ovf",       bus.ovf,       0);
`endif
      #10 rst_n = 1'b1;

      // Basic carry with latency check: out_valid exactly WORDS edges after accept.
      push(32'h0000_0100, 1'b0, 1'b0);
      issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 0);
      for (int i = 1; i <= WORDS; i++) begin
         @(posedge clk); #1;
         chk($sformatf("latency_c%0d", i), bus.out_valid, (i == WORDS));
      end
      wait_idle();

      // Full carry propagation through every byte.
      push(32'h0000_0000, 1'b1, 1'b0);
      issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0);
      wait_idle();

      // Back-pressure with a pending new request.
      bus.out_ready = 1'b0;
      push(32'h0000_0007, 1'b0, 1'b0);
      issue(32'h0000_0003, 32'h0000_0004, 1'b0, 0);
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.out_valid) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      if (!ok) timeout("bp_out_valid");
      bus.in_valid = 1'b1;
      bus.a = 32'h8000_0000; bus.b = 32'h8000_0000; bus.cin = 1'b0;
      push(32'h0000_0000, 1'b1, 1'b1);
      n0 = acc_q.size();
      repeat (3) begin
         @(posedge clk); #1;
         chk("bp_in_ready", bus.in_ready, 0);
         chk("bp_sum",      bus.sum,      32'h0000_0007);
         chk("bp_cout",     bus.cout,     0);
      end
      chk("bp_no_accept", acc_q.size(), n0);
      bus.out_ready = 1'b1;
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (acc_q.size() > n0) begin ok = 1; break; end
      end
      bus.in_valid = 1'b0;
      if (!ok) timeout("bp_accept");
      else chk("bp_accept_after_hs", acc_q[$], last_hs + 1);
      wait_idle();

      // Reset in the middle of ADD (idx==2): the operation is dropped.
      issue(32'h0101_0101, 32'h0101_0101, 1'b0, 0);
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready",  bus.in_ready,  1);
      chk("mid_rst_out_valid", bus.out_valid, 0);
      chk("mid_rst_sum",       bus.sum,       0);
      chk("mid_rst_cout",      bus.cout,      0);
`ifdef ADD_SEQ_OVF_EN
      chk("mid_rst_ovf",       bus.ovf,       0);
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_in_ready", bus.in_ready, 1);
      repeat (WORDS + 2) begin
         @(posedge clk); #1;
         chk("post_rst_no_valid", bus.out_valid, 0);
      end
      push(32'h2345_6789, 1'b0, 1'b0);
      issue(32'h1234_5678, 32'h1111_1111, 1'b0, 0);
      wait_idle();

      // Back-to-back with in_valid and out_ready held high.
      n0 = acc_q.size();
      push(32'h0000_0003, 1'b0, 1'b0);
      push(32'h0000_0000, 1'b1, 1'b0);
      issue(32'h0000_0001, 32'h0000_0002, 1'b0, 1);
      issue(32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b1, 0);
      if (acc_q.size() >= n0 + 2)
         chk("b2b_spacing", acc_q[n0+1] - acc_q[n0], WORDS + 2);
      else
         timeout("b2b_accepts");
      wait_idle();

      // Signed overflow corners.
      push(32'h8000_0000, 1'b0, 1'b1);
      issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
      wait_idle();
      push(32'h0000_0000, 1'b1, 1'b0);
      issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
      wait_idle();

      chk("queue_drained", expq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
